// File: rtl/interp_fir_pkg.sv
// rtl/interp_fir_pkg.sv - shared types, constants and default taps for the TX interpolating FIR
package interp_fir_pkg;

  typedef logic signed [15:0] coeff_t;

  // Q1.15 round-half-up: add half an LSB of the output, then drop the fraction.
  localparam int ROUND_CONST = 16384;
  localparam int FRAC_BITS   = 15;

  typedef enum logic {IDLE, EMIT} state_e;

  // 24-tap symmetric low-pass prototype for L=4; each polyphase branch
  // h[p], h[p+4], ..., h[p+20] sums to 32768 so DC gain is unity per output.
  localparam coeff_t DEFAULT_COEFFS [0:23] = '{
    -16'sd97,    -16'sd192,   -16'sd256,   16'sd1,
    16'sd1024,   16'sd2560,   16'sd4608,   16'sd6912,
    16'sd9216,   16'sd11008,  16'sd15040,  16'sd15712,
    16'sd15712,  16'sd15040,  16'sd11008,  16'sd9216,
    16'sd6912,   16'sd4608,   16'sd2560,   16'sd1024,
    16'sd1,      -16'sd256,   -16'sd192,   -16'sd97
  };

endpackage

// File: rtl/interp_fir_phase_mac.sv
// rtl/interp_fir_phase_mac.sv - one-phase dot product with round and narrow (INTERP_FIR_SAT_EN selects saturate vs wrap)
module interp_fir_phase_mac
  import interp_fir_pkg::*;
#(
  parameter int     L      = 4,
  parameter int     NTAPS  = 24,
  parameter int     WI     = 16,
  parameter int     WCOEFF = 16,
  parameter int     WO     = 16,
  parameter coeff_t COEFFS [0:NTAPS-1] = DEFAULT_COEFFS
) (
  input  logic signed [WI-1:0]        i_dline [0:NTAPS/L-1],
  input  logic        [$clog2(L)-1:0] i_phase,
`ifdef INTERP_FIR_SAT_EN
  output logic                        o_sat,
`endif
  output logic signed [WO-1:0]        o_data
);

  localparam int NB = NTAPS / L;
  localparam int AW = WI + WCOEFF + $clog2(NB);
  localparam int IW = $clog2(NTAPS);

  logic signed [AW-1:0] w_acc;
  logic        [IW-1:0] w_idx;

  // Full-width accumulate of the delay line against the taps of the selected phase
  always_comb begin
    w_acc = '0;
    w_idx = '0;
    for (int k = 0; k < NB; k++) begin
      w_idx = IW'(i_phase) + IW'(L * k);
      w_acc = w_acc + AW'(i_dline[k]) * AW'(COEFFS[w_idx]);
    end
  end

`ifdef INTERP_FIR_SAT_EN
  localparam logic signed [AW-1:0] MAXV = {{(AW-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-WO+1){1'b1}}, {(WO-1){1'b0}}};

  logic signed [AW-1:0] w_rnd;
  assign w_rnd = (w_acc + AW'(ROUND_CONST)) >>> FRAC_BITS;

  // Clip the rounded result to the output range and flag any clipped beat
  always_comb begin
    o_sat  = 1'b0;
    o_data = WO'(w_rnd);
    if (w_rnd > MAXV) begin
      o_data = {1'b0, {(WO-1){1'b1}}};
      o_sat  = 1'b1;
    end else if (w_rnd < MINV) begin
      o_data = {1'b1, {(WO-1){1'b0}}};
      o_sat  = 1'b1;
    end
  end
`else
  // Out-of-range results simply wrap (two's complement truncation)
  assign o_data = WO'((w_acc + AW'(ROUND_CONST)) >>> FRAC_BITS);
`endif

endmodule

// File: rtl/interp_fir_tx.sv
// rtl/interp_fir_tx.sv - polyphase interpolating FIR for the MSK TX path (optional INTERP_FIR_SAT_EN adds saturation and m_sat)
module interp_fir_tx
  import interp_fir_pkg::*;
#(
  parameter int     L      = 4,
  parameter int     NTAPS  = 24,
  parameter int     WI     = 16,
  parameter int     WCOEFF = 16,
  parameter int     WO     = 16,
  parameter coeff_t COEFFS [0:NTAPS-1] = DEFAULT_COEFFS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WI-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [WO-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
`ifdef INTERP_FIR_SAT_EN
  output logic                        m_sat,
`endif
  output logic        [$clog2(L)-1:0] m_phase
);

  localparam int NB = NTAPS / L;
  localparam int PW = $clog2(L);
  localparam logic [PW-1:0] LAST_PHASE = PW'(L - 1);

  state_e               r_state;
  state_e               w_state_next;
  logic        [PW-1:0] r_phase;
  logic        [PW-1:0] w_phase_next;
  logic signed [WI-1:0] r_dline [0:NB-1];
  logic                 w_last;
  logic                 w_fire_in;

  assign w_last    = (r_phase == LAST_PHASE);
  assign w_fire_in = s_valid && s_ready;
  assign m_phase   = r_phase;

  // State and phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  // Next state: step through phases on m_ready, chain straight into the next sample when one arrives on the last phase
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    case (r_state)
      IDLE: begin
        if (w_fire_in) begin
          w_state_next = EMIT;
          w_phase_next = '0;
        end
      end
      EMIT: begin
        if (m_ready) begin
          if (!w_last) begin
            w_phase_next = r_phase + 1'b1;
          end else begin
            w_phase_next = '0;
            w_state_next = w_fire_in ? EMIT : IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_phase_next = '0;
      end
    endcase
  end

  // Handshake outputs; s_ready only opens mid-burst when the last phase is being taken
  always_comb begin
    m_valid = (r_state == EMIT);
    s_ready = !m_valid || (m_ready && w_last);
  end

  // Delay line: newest sample at index 0, shifted only on an accepted input
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) r_dline[k] <= '0;
    end else if (w_fire_in) begin
      r_dline[0] <= s_data;
      for (int k = 1; k < NB; k++) r_dline[k] <= r_dline[k-1];
    end
  end

  // Output sample is a pure function of registered state, so it holds while stalled
  interp_fir_phase_mac #(
    .L      (L),
    .NTAPS  (NTAPS),
    .WI     (WI),
    .WCOEFF (WCOEFF),
    .WO     (WO),
    .COEFFS (COEFFS)
  ) u_mac (
    .i_dline (r_dline),
    .i_phase (r_phase),
`ifdef INTERP_FIR_SAT_EN
    .o_sat   (m_sat),
`endif
    .o_data  (m_data)
  );

endmodule

// File: doc/interp_fir_tx.md
Name: interp_fir_tx

Overview:
Polyphase interpolating FIR for the MSK modem transmit path; it is the TX-side counterpart of the post-DDC receive low-pass filter.
- Accepts symbol-rate baseband samples and emits L filtered samples per input, for pulse shaping and image rejection ahead of the DUC.
- Uses stream valid/ready on both sides with full backpressure.
- Coefficients are Q1.15 signed, with a fixed round-and-narrow output stage.

Parameters:
L, 4, interpolation factor (≥2)
NTAPS, 24, prototype filter length; must be a multiple of L
WI, 16, input sample width (signed)
WCOEFF, 16, coefficient width (signed Q1.15)
WO, 16, output sample width (signed)
COEFFS, interp_fir_pkg::DEFAULT_COEFFS, prototype taps h[0..NTAPS-1]

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_data  in  WI  input sample
s_valid  in  1  input sample valid
s_ready  out  1  block can accept s_data this cycle
m_data  out  WO  interpolated output sample
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data
m_phase  out  $clog2(L)  polyphase index of current m_data (0..L-1)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Delay line (NTAPS/L words) is cleared to 0.
  - m_valid=0, m_data=0, m_phase=0.
  - s_ready=1 on the first cycle after rst deasserts.
- Input transfer occurs when s_valid && s_ready. On transfer, x[n]=s_data is shifted into the delay line: d[0]=x[n], d[k]=x[n-k].
- Output phase p of input n: acc = Σ_{k=0}^{NTAPS/L-1} d[k]*COEFFS[p+L*k], computed at full width WI+WCOEFF+$clog2(NTAPS/L).
- m_data = sat_WO((acc + 2^14) >>> 15), i.e. round half up. Without INTERP_FIR_SAT_EN the result is truncated to WO bits (wrap).
- State machine:
  - IDLE: m_valid=0, s_ready=1. On input transfer go to EMIT with phase=0.
  - EMIT: m_valid=1, m_data/m_phase hold their values while !m_ready.
    - On m_ready with phase<L-1: phase+1 on the next cycle.
    - On m_ready with phase==L-1: if an input transfer happens the same cycle, restart at phase 0 for the new sample with no bubble; otherwise go to IDLE.
- s_ready = !m_valid || (m_ready && m_phase==L-1). This is combinational from m_ready; there is no other combinational path.
- Latency: phase 0 of x[n] is on m_data the cycle after the input transfer.
- Throughput: one input per L cycles with m_ready held high, giving 100% output duty cycle.
- Backpressure:
  - m_ready low for any number of cycles freezes all state.
  - Inputs are never dropped or duplicated.
  - Every input produces exactly L outputs, phases 0..L-1 in order.
- Reset mid-EMIT: remaining phases are discarded and the delay line is cleared. The next output after reset is phase 0 of the next input.
- Coefficient constraint for DEFAULT_COEFFS: each polyphase branch sums to 32768, giving unity DC gain per output sample.

Optional Feature:
INTERP_FIR_SAT_EN:
- Defined: the narrowing stage saturates to [-2^(WO-1), 2^(WO-1)-1], and an extra output port m_sat (1 bit) is added. m_sat is high alongside m_valid for any beat that was clipped, held with m_data, and reset to 0.
- Undefined: no m_sat port; out-of-range results wrap as two's complement truncation.

Decomposition:
- interp_fir_pkg:
  - coeff_t (signed [15:0])
  - DEFAULT_COEFFS (24-tap symmetric, L=4, per-phase sum 32768)
  - ROUND_CONST=2^14, FRAC_BITS=15
  - state_e {IDLE, EMIT}
- Sub-module interp_fir_phase_mac: combinational dot product of the delay line with one selected phase's taps, plus round and saturate/wrap. It is instantiated once, with the phase index as a mux select.

Test Plan:
- Impulse: s_data=16384 then zeros, m_ready=1 → 24 outputs equal to round-half-up(h[i]/2), in order i=0..23 (m_phase cycling 0..3), then zeros.
- DC: constant s_data=8192, m_ready=1 → after 6 inputs every m_data=8192 on every phase; s_ready toggles 1 of every 4 cycles; m_valid stays high with no gaps.
- Backpressure: random m_ready at 30% high with the same impulse → output sequence identical to the m_ready=1 case; m_data stable while m_valid && !m_ready; s_ready never high mid-burst.
- Reset mid-burst: rst asserted during phase 2 of an input of 16384 → next cycle m_valid=0; the following impulse reproduces the clean impulse response, with no residue from the prior sample.
- Saturation (INTERP_FIR_SAT_EN defined): override COEFFS with phase-0 taps=16384 and all others 0, constant input 32767 → phase-0 m_data=32767, m_sat=1; other phases m_data=0, m_sat=0. Without the macro, phase-0 m_data equals the low 16 bits of 98301 (i.e. -32771 mod 2^16 = 32765).
- Input starvation: s_valid low for 10 cycles between samples → m_valid low during the gap and returns to IDLE; the next input produces phase 0 one cycle after transfer.
